led_hunt_game: RTL and testbench
================================

# led_hunt_game

Parametrised LED-hunt game core for the labkit: a debounced player cursor moves along an N-LED strip, a pseudo-random target is spawned on demand, and hits, misses and win/lose status are tracked. Score and misses are shown on the multiplexed 4-digit seven-segment display. It replaces the fixed 8-LED, single-digit, timeout-free game and sits directly between the labkit buttons and the `led`/`seg`/`dig` pins.

## Interface
- N_LEDS, 8, strip width; must be 4, 8 or 16 (power of two).
- WIN_SCORE, 9, hits needed to win; range 1..99.
- MAX_MISSES, 3, target timeouts that end the game; range 1..9.
- TIMEOUT_CYCLES, 300_000_000, cycles a target stays lit before it counts as a miss.
- DEBOUNCE_CYCLES, 1_000_000, stable cycles needed to accept a button level change.
- REFRESH_CYCLES, 100_000, cycles each display digit is driven.
- clk_100mhz  in  1  sole clock.
- rst_n  in  1  reset; asynchronous, active-low.
- btn_left, btn_right  in  1  move cursor up/down the strip; raw, active-high.
- btn_up  in  1  spawn target; raw, active-high.
- btn_enter  in  1  restart game; raw, active-high.
- led  out  N_LEDS  cursor OR target, or the end-of-game pattern.
- seg  out  8  segments a..g on [6:0], dp on [7]; active-low.
- dig  out  4  digit enables; active-low.
- state  out  2  00 IDLE, 01 ARMED, 10 WIN, 11 LOSE.
- score_bcd  out  8  tens on [7:4], ones on [3:0].
- misses  out  4  binary miss count.

## Operation
- Button conditioning, per button:
  - 2-flop synchroniser.
  - The debounced level flips after the synced value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - A 1-cycle registered pulse is generated on each debounced rising edge.
- Cursor `pos` (log2 N_LEDS bits):
  - left pulse: pos+1; right pulse: pos-1.
  - Both wrap modulo N_LEDS.
  - Left and right pulses in the same cycle: no move.
  - Moves in IDLE and ARMED only.
- A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances every cycle, in all states.
- IDLE, btn_up pulse: tgt = lfsr[log2 N-1:0], incremented by 1 (wrapped) if it equals pos; clear timer; go ARMED.
- ARMED:
  - Hit (pos == tgt): score +1 in BCD (ones 9→0 carries into tens). Go WIN if the new score equals WIN_SCORE, else IDLE.
  - Timer reaches TIMEOUT_CYCLES-1 without a hit: misses +1. Go LOSE if the new count equals MAX_MISSES, else IDLE.
  - Hit and timeout in the same cycle: hit wins; misses unchanged.
  - btn_up is ignored.
- btn_enter pulse, any state: score=0, misses=0, pos=0, go IDLE. This has priority over all other events that cycle.
- led:
  - IDLE: onehot(pos).
  - ARMED: onehot(pos) | onehot(tgt).
  - WIN: all ones.
  - LOSE: alternating 1010… (MSB=1).
- Display:
  - A refresh counter rotates the active digit 0→1→2→3→0 every REFRESH_CYCLES. dig[k] is low only while digit k is active.
  - Digit content: dig0 = score ones, dig1 = score tens, dig2 = blank (seg=8'hFF), dig3 = misses.
  - Hex-to-seg decode is standard (0 = 8'hC0). dp stays high (off).

## Timing
- Reset values:
  - pos=0, tgt=0, score_bcd=0, misses=0, state=IDLE.
  - led = 1 on bit 0 only, all other bits 0.
  - dig=4'b1110, seg=8'hC0.
  - Debounced levels and pulses 0. lfsr = seed.
- Press latency: a raw press held steady gives its pulse at edge DEBOUNCE_CYCLES+3, counting the first edge that samples it high as edge 1. Cursor/state update on the following edge.
- Hit detection compares the registered pos and tgt. The score and state update on the edge after pos first equals tgt. `led` reflects the new state on that same edge.
- Timer counts from 0 on the ARMED entry edge. A miss registers exactly TIMEOUT_CYCLES edges after entry.
- Reset assertion mid-game immediately forces all reset values; no pulse survives it.
- A button held indefinitely produces exactly one pulse.

## Test plan
- Reset, N_LEDS=8, DEBOUNCE_CYCLES=4 -> led=8'h01, state=00, dig=1110, seg=C0. One left press -> led=8'h02 at edge 8 after press. Eight left presses from pos 0 -> wraps back to led=8'h01.
- Glitch on btn_left of 3 cycles -> no pulse, pos unchanged. Left and right presses made simultaneously -> pos unchanged.
- btn_up in IDLE -> state=01, two bits lit in led, tgt≠pos. Force tgt via the seeded LFSR and step the cursor onto it -> score_bcd=8'h01, state=00, single LED lit.
- WIN_SCORE=12, 12 hits -> score_bcd passes 09→10 correctly, ends 8'h12, state=10, led=8'hFF. btn_enter -> score 0, state 00.
- TIMEOUT_CYCLES=100, MAX_MISSES=2: spawn, idle 100 cycles -> misses=1, state=00. Repeat -> misses=2, state=11, led=8'hAA. Hit landing on the timeout cycle -> score +1, misses unchanged.
- REFRESH_CYCLES=8, score 8'h37, misses 2 -> dig sequence 1110,1101,1011,0111, each held 8 cycles. seg shows 7 (F8), 3 (B0), blank (FF), 2 (A4). Reset mid-rotation -> dig=1110 immediately.

Source files
------------

// File: rtl/led_hunt_game.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : led_hunt_game
//  Description : LED-hunt game core. A debounced cursor walks an N_LEDS strip,
//                btn_up spawns a pseudo-random target, landing the cursor on
//                it scores a hit, and leaving it lit for TIMEOUT_CYCLES counts
//                a miss. Score and misses are shown on a multiplexed 4-digit
//                seven-segment display.
//  Ports       : clk_100mhz            - sole clock
//                rst_n                 - asynchronous active-low reset
//                btn_left/right/up/enter - raw active-high buttons
//                led[N_LEDS-1:0]       - cursor | target, or end-of-game pattern
//                seg[7:0]              - active-low segments (dp on [7])
//                dig[3:0]              - active-low digit enables
//                state[1:0]            - 00 IDLE, 01 ARMED, 10 WIN, 11 LOSE
//                score_bcd[7:0]        - tens [7:4], ones [3:0]
//                misses[3:0]           - binary miss count
//  Revision    : 1.0 - initial release
// ============================================================================
module led_hunt_game #(
    parameter int N_LEDS          = 8,
    parameter int WIN_SCORE       = 9,
    parameter int MAX_MISSES      = 3,
    parameter int TIMEOUT_CYCLES  = 300_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REFRESH_CYCLES  = 100_000
) (
    input  logic              clk_100mhz,
    input  logic              rst_n,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_up,
    input  logic              btn_enter,
    output logic [N_LEDS-1:0] led,
    output logic [7:0]        seg,
    output logic [3:0]        dig,
    output logic [1:0]        state,
    output logic [7:0]        score_bcd,
    output logic [3:0]        misses
);

    localparam int c_PW = $clog2(N_LEDS);
    localparam int c_DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_RW = $clog2(REFRESH_CYCLES + 1);

    localparam logic [c_DW-1:0]   c_DB_LAST      = c_DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TW-1:0]   c_TIMEOUT_LAST = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_RW-1:0]   c_REF_LAST     = c_RW'(REFRESH_CYCLES - 1);
    localparam logic [7:0]        c_WIN_BCD      = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
    localparam logic [3:0]        c_MAX_MISS     = 4'(MAX_MISSES);
    localparam logic [15:0]       c_LFSR_SEED    = 16'hACE1;
    localparam logic [N_LEDS-1:0] c_ONE          = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] c_LOSE_PAT     = {(N_LEDS / 2){2'b10}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_WIN   = 2'b10,
        ST_LOSE  = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning: sync, debounce, rising-edge pulse
    // ------------------------------------------------------------------
    logic [3:0] w_btn_raw;
    logic [3:0] w_pulse;

    assign w_btn_raw = {btn_enter, btn_up, btn_right, btn_left};

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        logic            r_s1;
        logic            r_s2;
        logic            r_deb;
        logic            r_deb_d;
        logic            r_pulse;
        logic [c_DW-1:0] r_cnt;

        always_ff @(posedge clk_100mhz or negedge rst_n) begin
            if (!rst_n) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_deb   <= 1'b0;
                r_deb_d <= 1'b0;
                r_pulse <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s1 <= w_btn_raw[gi];
                r_s2 <= r_s1;
                // Count consecutive cycles of disagreement; any agreement restarts it.
                if (r_s2 != r_deb) begin
                    if (r_cnt == c_DB_LAST) begin
                        r_deb <= ~r_deb;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_DW'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
                r_deb_d <= r_deb;
                r_pulse <= r_deb & ~r_deb_d;
            end
        end

        assign w_pulse[gi] = r_pulse;
    end

    logic w_left, w_right, w_up, w_enter;
    assign w_left  = w_pulse[0];
    assign w_right = w_pulse[1];
    assign w_up    = w_pulse[2];
    assign w_enter = w_pulse[3];

    // ------------------------------------------------------------------
    // Game state registers
    // ------------------------------------------------------------------
    state_t          r_state, w_state;
    logic [c_PW-1:0] r_pos, w_pos;
    logic [c_PW-1:0] r_tgt, w_tgt;
    logic [7:0]      r_score, w_score;
    logic [3:0]      r_misses, w_misses;
    logic [c_TW-1:0] r_timer, w_timer;
    logic [15:0]     r_lfsr;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_pos    <= '0;
            r_tgt    <= '0;
            r_score  <= '0;
            r_misses <= '0;
            r_timer  <= '0;
            r_lfsr   <= c_LFSR_SEED;
        end else begin
            r_state  <= w_state;
            r_pos    <= w_pos;
            r_tgt    <= w_tgt;
            r_score  <= w_score;
            r_misses <= w_misses;
            r_timer  <= w_timer;
            // Right-shifting Fibonacci form: taps 16,14,13,11 are bits 0,2,3,5.
            r_lfsr   <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        end
    end

    logic [c_PW-1:0] w_lfsr_tgt;
    logic [c_PW-1:0] w_spawn_tgt;
    logic [7:0]      w_score_inc;
    logic [3:0]      w_miss_inc;
    logic            w_hit;
    logic            w_timeout;

    assign w_lfsr_tgt  = r_lfsr[c_PW-1:0];
    // Never spawn under the cursor, otherwise the target would be hit for free.
    assign w_spawn_tgt = (w_lfsr_tgt == r_pos) ? w_lfsr_tgt + c_PW'(1) : w_lfsr_tgt;
    assign w_score_inc = (r_score[3:0] == 4'd9) ? {r_score[7:4] + 4'd1, 4'd0}
                                                : {r_score[7:4], r_score[3:0] + 4'd1};
    assign w_miss_inc  = r_misses + 4'd1;
    assign w_hit       = (r_pos == r_tgt);
    assign w_timeout   = (r_timer == c_TIMEOUT_LAST);

    always_comb begin
        w_state  = r_state;
        w_pos    = r_pos;
        w_tgt    = r_tgt;
        w_score  = r_score;
        w_misses = r_misses;
        w_timer  = r_timer;
        if (w_enter) begin
            w_state  = ST_IDLE;
            w_pos    = '0;
            w_score  = '0;
            w_misses = '0;
        end else begin
            if ((r_state == ST_IDLE || r_state == ST_ARMED) && (w_left ^ w_right)) begin
                w_pos = w_left ? r_pos + c_PW'(1) : r_pos - c_PW'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_up) begin
                        w_tgt   = w_spawn_tgt;
                        w_timer = '0;
                        w_state = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // A hit on the timeout cycle takes precedence over the miss.
                    if (w_hit) begin
                        w_score = w_score_inc;
                        w_state = (w_score_inc == c_WIN_BCD) ? ST_WIN : ST_IDLE;
                    end else if (w_timeout) begin
                        w_misses = w_miss_inc;
                        w_state  = (w_miss_inc == c_MAX_MISS) ? ST_LOSE : ST_IDLE;
                    end else begin
                        w_timer = r_timer + c_TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // LED strip
    // ------------------------------------------------------------------
    logic [N_LEDS-1:0] w_pos_oh;
    logic [N_LEDS-1:0] w_tgt_oh;
    assign w_pos_oh = c_ONE << r_pos;
    assign w_tgt_oh = c_ONE << r_tgt;

    always_comb begin
        led = w_pos_oh;
        case (r_state)
            ST_ARMED: led = w_pos_oh | w_tgt_oh;
            ST_WIN:   led = '1;
            ST_LOSE:  led = c_LOSE_PAT;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Seven-segment multiplexing
    // ------------------------------------------------------------------
    logic [c_RW-1:0] r_ref_cnt;
    logic [1:0]      r_digit;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_cnt <= '0;
            r_digit   <= 2'd0;
        end else if (r_ref_cnt == c_REF_LAST) begin
            r_ref_cnt <= '0;
            r_digit   <= r_digit + 2'd1;
        end else begin
            r_ref_cnt <= r_ref_cnt + c_RW'(1);
        end
    end

    function automatic logic [7:0] f_hex7(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    logic [3:0] w_digit_val;
    logic       w_blank;

    always_comb begin
        w_digit_val = 4'd0;
        w_blank     = 1'b0;
        case (r_digit)
            2'd0:    w_digit_val = r_score[3:0];
            2'd1:    w_digit_val = r_score[7:4];
            2'd2:    w_blank     = 1'b1;
            default: w_digit_val = r_misses;
        endcase
        seg = w_blank ? 8'hFF : f_hex7(w_digit_val);
        dig = ~(4'b0001 << r_digit);
    end

    assign state     = r_state;
    assign score_bcd = r_score;
    assign misses    = r_misses;

endmodule
`default_nettype wire

// File: tb/tb_led_hunt_game.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_led_hunt_game
//  Description : Bench for led_hunt_game with a small configuration. A
//                behavioural model tracks the game in plain integers and is
//                compared against every DUT output each cycle; directed
//                sequences add literal expectations for the key scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_hunt_game;

    localparam int N    = 8;
    localparam int WIN  = 12;
    localparam int MAXM = 2;
    localparam int T    = 100;
    localparam int D    = 4;
    localparam int R    = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bl = 1'b0, br = 1'b0, bu = 1'b0, be = 1'b0;
    logic [7:0] led, seg, score_bcd;
    logic [3:0] dig, misses;
    logic [1:0] state;

    led_hunt_game #(
        .N_LEDS(N), .WIN_SCORE(WIN), .MAX_MISSES(MAXM),
        .TIMEOUT_CYCLES(T), .DEBOUNCE_CYCLES(D), .REFRESH_CYCLES(R)
    ) dut (
        .clk_100mhz(clk), .rst_n(rst_n),
        .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_enter(be),
        .led(led), .seg(seg), .dig(dig), .state(state),
        .score_bcd(score_bcd), .misses(misses)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int          m_s1[4], m_s2[4], m_lvl[4], m_run[4], m_prv[4], m_pls[4];
    int          m_pos, m_tgt, m_score, m_misses, m_state, m_age, m_tick;
    logic [15:0] m_lfsr;
    logic [7:0]  seg_tab[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        logic fb;
        fb = ^(x & 16'h002D);
        return (x >> 1) | (16'(fb) << 15);
    endfunction

    function automatic int raw_btn(input int b);
        case (b)
            0:       return int'(bl);
            1:       return int'(br);
            2:       return int'(bu);
            default: return int'(be);
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0;
                m_run[b] = 0; m_prv[b] = 0; m_pls[b] = 0;
            end
            m_pos = 0; m_tgt = 0; m_score = 0; m_misses = 0;
            m_state = 0; m_age = 0; m_tick = 0; m_lfsr = 16'hACE1;
        end else begin
            int old_pos;
            old_pos = m_pos;
            if (m_pls[3] == 1) begin
                m_score = 0; m_misses = 0; m_pos = 0; m_state = 0;
            end else begin
                if (m_state <= 1 && m_pls[0] != m_pls[1])
                    m_pos = (m_pls[0] == 1) ? (m_pos + 1) % N : (m_pos + N - 1) % N;
                if (m_state == 0) begin
                    if (m_pls[2] == 1) begin
                        int t;
                        t = int'(m_lfsr) % N;
                        if (t == old_pos) t = (t + 1) % N;
                        m_tgt = t; m_age = 0; m_state = 1;
                    end
                end else if (m_state == 1) begin
                    m_age++;
                    if (old_pos == m_tgt) begin
                        m_score++;
                        m_state = (m_score == WIN) ? 2 : 0;
                    end else if (m_age == T) begin
                        m_misses++;
                        m_state = (m_misses == MAXM) ? 3 : 0;
                    end
                end
            end
            for (int b = 0; b < 4; b++) begin
                int np;
                np = (m_lvl[b] == 1 && m_prv[b] == 0) ? 1 : 0;
                m_prv[b] = m_lvl[b];
                if (m_s2[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == D) begin
                        m_lvl[b] = m_s2[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = raw_btn(b);
                m_pls[b] = np;
            end
            m_lfsr = lfsr_next(m_lfsr);
            m_tick++;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        int e_led, digit, e_dig, e_seg;
        case (m_state)
            0: e_led = 1 << m_pos;
            1: e_led = (1 << m_pos) | (1 << m_tgt);
            2: e_led = (1 << N) - 1;
            default: begin
                e_led = 0;
                for (int i = 1; i < N; i += 2) e_led |= (1 << i);
            end
        endcase
        digit = (m_tick / R) % 4;
        e_dig = 15 ^ (1 << digit);
        case (digit)
            0: e_seg = int'(seg_tab[m_score % 10]);
            1: e_seg = int'(seg_tab[m_score / 10]);
            2: e_seg = 8'hFF;
            default: e_seg = int'(seg_tab[m_misses]);
        endcase
        check("led", 32'(led), e_led);
        check("seg", 32'(seg), e_seg);
        check("dig", 32'(dig), e_dig);
        check("state", 32'(state), m_state);
        check("score", 32'(score_bcd), ((m_score / 10) << 4) | (m_score % 10));
        check("misses", 32'(misses), m_misses);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       bl = v;
            1:       br = v;
            2:       bu = v;
            default: be = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        tick(D + 5);
        set_btn(b, 1'b0);
        tick(D + 4);
    endtask

    // Wait until an up press started now will spawn with the LFSR equal to
    // the cursor, so the target lands at pos+1.
    task automatic wait_adjacent_spawn();
        int found;
        found = 0;
        for (int k = 0; k < 400 && found == 0; k++) begin
            logic [15:0] x;
            x = m_lfsr;
            repeat (D + 3) x = lfsr_next(x);
            if (int'(x) % N == m_pos) found = 1;
            else tick(1);
        end
        check("spawn_plan", found, 1);
    endtask

    task automatic adjacent_hit();
        wait_adjacent_spawn();
        press(2);
        press(0);
    endtask

    logic [3:0] dig_lit[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] seg_lit[4] = '{8'hA4, 8'hF9, 8'hFF, 8'hC0};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tick(3);
        check("rst_led", 32'(led), 8'h01);
        check("rst_state", 32'(state), 0);
        check("rst_dig", 32'(dig), 4'hE);
        check("rst_seg", 32'(seg), 8'hC0);
        rst_n = 1'b1;
        tick(2);

        // one left press: cursor moves on edge D+4 = 8
        bl = 1'b1;
        repeat (7) @(posedge clk);
        #1 check("press_e7", 32'(led), 8'h01);
        @(posedge clk);
        #1 check("press_e8", 32'(led), 8'h02);
        tick(2);
        bl = 1'b0;
        tick(D + 4);

        repeat (7) press(0);
        check("wrap", 32'(led), 8'h01);

        // held button: exactly one move
        bl = 1'b1;
        tick(40);
        bl = 1'b0;
        tick(D + 4);
        check("held_once", 32'(led), 8'h02);
        press(1);
        check("right", 32'(led), 8'h01);

        // 3-cycle glitch
        bl = 1'b1;
        tick(3);
        bl = 1'b0;
        tick(D + 6);
        check("glitch", 32'(led), 8'h01);

        // simultaneous left+right
        bl = 1'b1; br = 1'b1;
        tick(D + 5);
        bl = 1'b0; br = 1'b0;
        tick(D + 4);
        check("lr_same", 32'(led), 8'h01);

        // spawn and steer onto the target
        press(2);
        check("spawn_state", 32'(state), 1);
        check("spawn_two", $countones(led), 2);
        for (int k = 0; k < 8 && m_pos != m_tgt; k++) begin
            if ((m_tgt - m_pos + N) % N <= N / 2) press(0);
            else press(1);
        end
        check("hit1_score", 32'(score_bcd), 8'h01);
        check("hit1_state", 32'(state), 0);
        check("hit1_led", $countones(led), 1);

        for (int h = 2; h <= WIN; h++) begin
            adjacent_hit();
            if (h == 9)  check("score_09", 32'(score_bcd), 8'h09);
            if (h == 10) check("score_10", 32'(score_bcd), 8'h10);
        end
        check("win_score", 32'(score_bcd), 8'h12);
        check("win_state", 32'(state), 2);
        check("win_led", 32'(led), 8'hFF);

        // display rotation at score 12, misses 0
        begin
            logic [3:0] prev;
            int ok;
            ok = 0;
            prev = dig;
            for (int k = 0; k < 40 && ok == 0; k++) begin
                tick(1);
                if (dig == 4'hE && prev != 4'hE) ok = 1;
                prev = dig;
            end
            check("rot_sync", ok, 1);
            for (int k = 0; k < 4 * R; k++) begin
                check("rot_dig", 32'(dig), 32'(dig_lit[k / R]));
                check("rot_seg", 32'(seg), 32'(seg_lit[k / R]));
                tick(1);
            end
        end

        press(3);
        check("enter_score", 32'(score_bcd), 0);
        check("enter_state", 32'(state), 0);
        check("enter_led", 32'(led), 8'h01);

        // timeouts
        press(2);
        tick(T + 10);
        check("miss1", 32'(misses), 1);
        check("miss1_state", 32'(state), 0);
        press(2);
        tick(T + 10);
        check("miss2", 32'(misses), 2);
        check("lose_state", 32'(state), 3);
        check("lose_led", 32'(led), 8'hAA);
        press(3);
        check("enter_misses", 32'(misses), 0);

        // hit detected on exactly the timeout cycle
        wait_adjacent_spawn();
        bu = 1'b1;
        tick(D + 5);
        bu = 1'b0;
        tick(T - 1 - (D + 5));
        bl = 1'b1;
        tick(D + 5);
        bl = 1'b0;
        tick(D + 9);
        check("edge_hit_score", 32'(score_bcd), 8'h01);
        check("edge_hit_misses", 32'(misses), 0);
        check("edge_hit_state", 32'(state), 0);

        // randomized play
        for (int it = 0; it < 300; it++) begin
            int mask, len;
            mask = $urandom_range(0, 7);
            if ($urandom_range(0, 15) == 0) mask |= 8;
            len = $urandom_range(1, 12);
            for (int b = 0; b < 4; b++) set_btn(b, logic'((mask >> b) & 1));
            tick(len);
            for (int b = 0; b < 4; b++) set_btn(b, 1'b0);
            tick($urandom_range(0, 10));
            if (it == 150) begin
                bl = 1'b1;
                @(posedge clk);
                #3 rst_n = 1'b0;
                #1;
                check("async_dig", 32'(dig), 4'hE);
                check("async_seg", 32'(seg), 8'hC0);
                check("async_state", 32'(state), 0);
                check("async_led", 32'(led), 8'h01);
                tick(2);
                rst_n = 1'b1;
                tick(2);
                bl = 1'b0;
            end
        end
        tick(5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
